// File: rtl/ahbslv_wbmas_bridge.sv
// AHB slave to WISHBONE classic master bridge.
// Every accepted AHB transfer becomes one single WB read or write cycle, and
// the WB result comes back as the AHB data-phase response. Bursts are split
// into single beats. There is one clock domain.
// Optional feature: define WB_TIMEOUT_EN to abort a WB cycle that gets no
// ack/err within TIMEOUT_CYCLES cycles. Such a cycle ends with an AHB ERROR.
module ahbslv_wbmas_bridge #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic          hwrite,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [DW-1:0] hwdata,
  input  logic          hready_i,
  output logic          hreadyout,
  output logic [1:0]    hresp,
  output logic [DW-1:0] hrdata,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_RESP,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          xfer_valid;
  logic          load_req;
  logic [3:0]    dec_sel;
  logic          dec_err;
  logic [AW-1:0] adr_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [DW-1:0] rdata_q;
  logic          tmo_hit;

  // An address phase counts only when selected, bus-ready and NONSEQ/SEQ.
  assign xfer_valid = hsel & hready_i & htrans[1];

  // Byte-lane decode and alignment check for the current address phase.
  always_comb begin
    dec_sel = 4'b0000;
    dec_err = 1'b0;
    case (hsize)
      3'b000: dec_sel = 4'b0001 << haddr[1:0];
      3'b001: begin
        dec_sel = haddr[1] ? 4'b1100 : 4'b0011;
        dec_err = haddr[0];
      end
      3'b010: begin
        dec_sel = 4'b1111;
        dec_err = (haddr[1:0] != 2'b00);
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Next state, AHB response and WB strobes, all decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    load_req  = 1'b0;
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    case (state)
      S_IDLE, S_RESP, S_ERR2: begin
        if (state == S_ERR2) hresp = RESP_ERROR;
        if (xfer_valid) begin
          state_nxt = dec_err ? S_ERR1 : S_WB_REQ;
          load_req  = !dec_err;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WB_REQ: begin
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        hreadyout = 1'b0;
        if (wb_err_i)      state_nxt = S_ERR1;
        else if (wb_ack_i) state_nxt = S_RESP;
        else if (tmo_hit)  state_nxt = S_ERR1;
      end
      S_ERR1: begin
        hresp     = RESP_ERROR;
        hreadyout = 1'b0;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge.
    if (!hresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Capture the address-phase attributes of a legal transfer for the WB cycle.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= 4'b0000;
    end else if (load_req) begin
      adr_q <= haddr;
      we_q  <= hwrite;
      sel_q <= dec_sel;
    end
  end

  // Read data changes only on a clean read ack. An err beats a simultaneous ack.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rdata_q <= '0;
    end else if (state == S_WB_REQ && wb_ack_i && !wb_err_i && !we_q) begin
      rdata_q <= wb_dat_i;
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Count WB_REQ cycles. The count is zero at entry, and on the last allowed
  // cycle the cycle is abandoned; a late ack then lands in ERR1 and is ignored.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)               tmo_cnt <= '0;
    else if (state != S_WB_REQ) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // WB side: address and lanes come from the capture registers; write data
  // passes straight through from the AHB data phase.
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q & (state == S_WB_REQ);
  assign wb_dat_o = (state == S_WB_REQ && we_q) ? hwdata : '0;
  assign hrdata   = rdata_q;

  // The bridge ignores burst type and the SEQ/NONSEQ difference.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0], (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_ahbslv_wbmas_bridge.sv
// Testbench for ahbslv_wbmas_bridge. An AHB driver, a simple WB slave model,
// and a WB scoreboard: the expected WB cycles are queued as stimulus is
// driven and compared when the DUT completes each WB cycle.
module tb_ahbslv_wbmas_bridge;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_i;
  logic        hready_ovr;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  int vectors     = 0;
  int miscompares = 0;

  ahbslv_wbmas_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready_i(hready_i), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 hclk = ~hclk;

  // Bus-wide HREADY follows the slave, unless a test holds it low.
  assign hready_i = hready_ovr ? 1'b0 : hreadyout;

  // ---------------- WB slave model ----------------
  logic        ack_en;
  logic        err_en;
  int          wait_n;
  logic [31:0] rd_val;
  int          wcnt;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                                          wcnt <= 0;
    else if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) wcnt <= wcnt + 1;
    else                                                   wcnt <= 0;
  end

  assign wb_ack_i = ack_en && wb_cyc_o && wb_stb_o && (wcnt == wait_n);
  assign wb_err_i = err_en && wb_cyc_o && wb_stb_o && (wcnt == wait_n);
  assign wb_dat_i = rd_val;

  // ---------------- WB monitor and scoreboard ----------------
  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_txn_t;

  wb_txn_t obs_arr[64];
  int      obs_n   = 0;
  int      wb_busy = 0;
  wb_txn_t exp_q[$];
  int      obs_rd  = 0;

  always @(negedge hclk) begin
    if (wb_cyc_o) wb_busy <= wb_busy + 1;
    if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i) && obs_n < 64) begin
      obs_arr[obs_n] <= '{adr: wb_adr_o, we: wb_we_o, sel: wb_sel_o, dat: wb_dat_o};
      obs_n          <= obs_n + 1;
    end
  end

  task automatic push_wb(input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat);
    exp_q.push_back('{adr: adr, we: we, sel: sel, dat: dat});
  endtask

  task automatic score_wb();
    wb_txn_t o;
    wb_txn_t e;
    while (obs_rd < obs_n) begin
      o = obs_arr[obs_rd];
      obs_rd++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_scoreboard: unexpected WB cycle adr=%h we=%b sel=%b dat=%h",
                 o.adr, o.we, o.sel, o.dat);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL wb_scoreboard: got adr=%h we=%b sel=%b dat=%h, expected adr=%h we=%b sel=%b dat=%h",
                   o.adr, o.we, o.sel, o.dat, e.adr, e.we, e.sel, e.dat);
        end
      end
    end
  endtask

  // ---------------- AHB driver ----------------
  // Called and returns at posedge+1. Drives one NONSEQ transfer and then
  // follows its data phase, with a bounded wait for the response.
  task automatic ahb_single(input logic [31:0] addr, input logic wr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            output int low_n, output logic [1:0] low_resp,
                            output logic [1:0] end_resp, output logic [31:0] rdata);
    hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wr ? wdata : 32'h0;
    low_n = 0; low_resp = 2'b00;
    @(negedge hclk);
    while (!hreadyout && low_n < 40) begin
      low_n++;
      low_resp = hresp;
      @(negedge hclk);
    end
    end_resp = hresp;
    rdata    = hrdata;
    @(posedge hclk); #1;
  endtask

  logic [31:0] last_rd_exp;

  // ---------------- tests ----------------
  task automatic test_reset();
    hresetn = 1'b1;
    #1 hresetn = 1'b0;
    #2;
    vectors++;
    if ({hreadyout, hresp, hrdata} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_ahb: got rdy=%b resp=%b rdata=%h, expected rdy=1 resp=00 rdata=0",
               hreadyout, hresp, hrdata);
    end
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o} !== {3'b000, 32'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_wb: got cyc=%b stb=%b we=%b adr=%h sel=%b, expected all zero",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o);
    end
    @(posedge hclk); @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    last_rd_exp = 32'h0;
  endtask

  task automatic test_word_write();
    int low_n; logic [1:0] lr; logic [1:0] er; logic [31:0] rd; int b0;
    ack_en = 1'b1; err_en = 1'b0; wait_n = 3;
    b0 = wb_busy;
    push_wb(32'h100, 1'b1, 4'b1111, 32'hDEADBEEF);
    ahb_single(32'h100, 1'b1, 3'b010, 32'hDEADBEEF, low_n, lr, er, rd);
    score_wb();
    vectors++;
    if (low_n !== 4) begin
      miscompares++;
      $display("FAIL word_write_wait: got %0d low cycles, expected 4", low_n);
    end
    vectors++;
    if ({lr, er} !== 4'b0000) begin
      miscompares++;
      $display("FAIL word_write_resp: got wait resp=%b final resp=%b, expected 00/00", lr, er);
    end
    vectors++;
    if (wb_busy - b0 !== 4) begin
      miscompares++;
      $display("FAIL word_write_cyc: got %0d cyc cycles, expected 4", wb_busy - b0);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  sel;
  } rd_vec_t;

  task automatic test_reads();
    int low_n; logic [1:0] lr; logic [1:0] er; logic [31:0] rd;
    rd_vec_t tbl[6];
    tbl[0] = '{32'h203, 3'b000, 4'b1000};
    tbl[1] = '{32'h200, 3'b000, 4'b0001};
    tbl[2] = '{32'h201, 3'b000, 4'b0010};
    tbl[3] = '{32'h200, 3'b001, 4'b0011};
    tbl[4] = '{32'h202, 3'b001, 4'b1100};
    tbl[5] = '{32'h204, 3'b010, 4'b1111};
    ack_en = 1'b1; err_en = 1'b0; wait_n = 0;
    for (int i = 0; i < 6; i++) begin
      rd_val = (i == 0) ? 32'h11223344 : (32'hA5000000 | 32'(i));
      push_wb(tbl[i].addr, 1'b0, tbl[i].sel, 32'h0);
      ahb_single(tbl[i].addr, 1'b0, tbl[i].size, 32'h0, low_n, lr, er, rd);
      score_wb();
      vectors++;
      if (low_n !== 1 || er !== 2'b00 || rd !== rd_val) begin
        miscompares++;
        $display("FAIL read_%0d: got low=%0d resp=%b rdata=%h, expected low=1 resp=00 rdata=%h",
                 i, low_n, er, rd, rd_val);
      end
      last_rd_exp = rd_val;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[3];
    int cycles; int n; int b0; logic [5:0] pat;
    d[0] = 32'h0A0A0A0A; d[1] = 32'h1B1B1B1B; d[2] = 32'h2C2C2C2C;
    ack_en = 1'b1; err_en = 1'b0; wait_n = 0;
    for (int k = 0; k < 3; k++) push_wb(32'(4 * k), 1'b1, 4'b1111, d[k]);
    b0 = wb_busy; cycles = 0; pat = '0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    for (int k = 0; k < 3; k++) begin
      hwdata = d[k];
      if (k < 2) begin
        haddr = 32'(4 * (k + 1)); htrans = 2'b11;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      n = 0;
      do begin
        @(negedge hclk);
        cycles++; n++;
        pat = {pat[4:0], hreadyout};
      end while (!hreadyout && n < 20);
      @(posedge hclk); #1;
    end
    score_wb();
    vectors++;
    if (cycles !== 6 || pat !== 6'b010101) begin
      miscompares++;
      $display("FAIL b2b_timing: got %0d cycles ready pattern %b, expected 6 cycles 010101",
               cycles, pat);
    end
    vectors++;
    if (wb_busy - b0 !== 3) begin
      miscompares++;
      $display("FAIL b2b_cyc: got %0d cyc cycles, expected 3", wb_busy - b0);
    end
  endtask

  task automatic test_errors();
    int low_n; logic [1:0] lr; logic [1:0] er; logic [31:0] rd; int b0;
    logic [31:0] ea[5];
    logic [2:0]  es[5];
    // WB error together with ack on a read: ERROR, and hrdata is not updated.
    ack_en = 1'b1; err_en = 1'b1; wait_n = 0; rd_val = 32'h5555AAAA;
    push_wb(32'h300, 1'b0, 4'b1111, 32'h0);
    ahb_single(32'h300, 1'b0, 3'b010, 32'h0, low_n, lr, er, rd);
    score_wb();
    vectors++;
    if (low_n !== 2 || lr !== 2'b01 || er !== 2'b01) begin
      miscompares++;
      $display("FAIL wb_err_resp: got low=%0d resp=%b/%b, expected low=2 resp=01/01", low_n, lr, er);
    end
    vectors++;
    if (rd !== last_rd_exp) begin
      miscompares++;
      $display("FAIL wb_err_rdata: got %h, expected held %h", rd, last_rd_exp);
    end
    err_en = 1'b0;
    // Decode errors: two-cycle ERROR, no WB cycle.
    ea[0] = 32'h1; es[0] = 3'b001;
    ea[1] = 32'h2; es[1] = 3'b010;
    ea[2] = 32'h1; es[2] = 3'b010;
    ea[3] = 32'h0; es[3] = 3'b011;
    ea[4] = 32'h0; es[4] = 3'b100;
    for (int i = 0; i < 5; i++) begin
      b0 = wb_busy;
      ahb_single(ea[i], i[0], es[i], 32'h12345678, low_n, lr, er, rd);
      vectors++;
      if (low_n !== 1 || lr !== 2'b01 || er !== 2'b01 || wb_busy != b0) begin
        miscompares++;
        $display("FAIL decode_err_%0d: got low=%0d resp=%b/%b wb_cycles=%0d, expected low=1 resp=01/01 wb_cycles=0",
                 i, low_n, lr, er, wb_busy - b0);
      end
    end
    score_wb();
  endtask

  task automatic test_no_transfer();
    int b0;
    logic       ps[4];
    logic [1:0] pt[4];
    logic       po[4];
    ps[0] = 1'b1; pt[0] = 2'b01; po[0] = 1'b0;  // BUSY
    ps[1] = 1'b1; pt[1] = 2'b10; po[1] = 1'b1;  // NONSEQ with HREADY low
    ps[2] = 1'b0; pt[2] = 2'b10; po[2] = 1'b0;  // not selected
    ps[3] = 1'b1; pt[3] = 2'b00; po[3] = 1'b0;  // IDLE
    b0 = wb_busy;
    haddr = 32'h400; hwrite = 1'b1; hsize = 3'b010;
    for (int i = 0; i < 4; i++) begin
      hsel = ps[i]; htrans = pt[i]; hready_ovr = po[i];
      for (int c = 0; c < 2; c++) begin
        @(negedge hclk);
        vectors++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00 || wb_cyc_o !== 1'b0) begin
          miscompares++;
          $display("FAIL no_xfer_%0d: got rdy=%b resp=%b cyc=%b, expected rdy=1 resp=00 cyc=0",
                   i, hreadyout, hresp, wb_cyc_o);
        end
        @(posedge hclk); #1;
      end
      // Drop the request before HREADY comes back so it is never sampled.
      hsel = 1'b0; htrans = 2'b00; hready_ovr = 1'b0;
    end
    vectors++;
    if (wb_busy != b0) begin
      miscompares++;
      $display("FAIL no_xfer_cyc: got %0d cyc cycles, expected 0", wb_busy - b0);
    end
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0; err_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h500; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    @(negedge hclk);
    vectors++;
    if (wb_cyc_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_pre: got cyc=%b, expected 1", wb_cyc_o);
    end
    #2 hresetn = 1'b0;
    #1;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, hreadyout, hresp, hrdata} !==
        {3'b000, 32'h0, 4'h0, 1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got cyc=%b stb=%b we=%b adr=%h sel=%b rdy=%b resp=%b rdata=%h, expected reset values",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, hreadyout, hresp, hrdata);
    end
    last_rd_exp = 32'h0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    ack_en = 1'b1;
    @(posedge hclk); #1;
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    int low_n; logic [1:0] lr; logic [1:0] er; logic [31:0] rd; int b0;
    ack_en = 1'b0; err_en = 1'b0;
    b0 = wb_busy;
    ahb_single(32'h600, 1'b0, 3'b010, 32'h0, low_n, lr, er, rd);
    vectors++;
    if (low_n !== 17 || lr !== 2'b01 || er !== 2'b01 || wb_busy - b0 !== 16) begin
      miscompares++;
      $display("FAIL timeout: got low=%0d resp=%b/%b wb_cycles=%0d, expected low=17 resp=01/01 wb_cycles=16",
               low_n, lr, er, wb_busy - b0);
    end
    ack_en = 1'b1;
  endtask
`endif

  initial begin
    hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'b000;
    hburst = 3'b000; hwdata = 32'h0; hready_ovr = 1'b0;
    ack_en = 1'b1; err_en = 1'b0; wait_n = 0; rd_val = 32'h0;
    test_reset();
    test_word_write();
    test_reads();
    test_back_to_back();
    test_errors();
    test_no_transfer();
    test_reset_mid();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge hclk);
    #1;
    score_wb();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wb_scoreboard_drain: got %0d expected WB cycles never seen, expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by itself");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahbslv_wbmas_bridge.md
Name: ahbslv_wbmas_bridge

Overview:
- Reverse-direction bridge: AHB slave in front, WISHBONE classic master behind it.
- Each valid AHB transfer becomes one single WB read or write cycle; results return as AHB data-phase response.
- Single clock domain; lets an AHB master (bus model or CPU) reach WISHBONE memories and peripherals.
- Bursts are broken into single beats.

Parameters:
- AW, 32, address width on both sides.
- DW, 32, data width. Fixed at 32; the byte-select decode depends on it.
- TIMEOUT_CYCLES, 16, WB wait limit in cycles. Used only when WB_TIMEOUT_EN is defined.

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hresetn  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  AW  transfer address.
- hwrite  in  1  1=write, 0=read.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize  in  3  000 byte, 001 halfword, 010 word.
- hburst  in  3  ignored.
- hwdata  in  DW  write data (data phase).
- hready_i  in  1  bus-wide HREADY.
- hreadyout  out  1  slave ready.
- hresp  out  2  OKAY=00, ERROR=01.
- hrdata  out  DW  read data.
- wb_adr_o  out  AW  WB address.
- wb_dat_o  out  DW  WB write data.
- wb_dat_i  in  DW  WB read data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  WB write enable.
- wb_cyc_o  out  1  WB cycle.
- wb_stb_o  out  1  WB strobe.
- wb_ack_i  in  1  WB acknowledge.
- wb_err_i  in  1  WB error.

Behaviour:
- Reset (hresetn=0, takes effect immediately, no clock needed):
  - hreadyout=1, hresp=00, hrdata=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_sel_o=0.
  - FSM to IDLE.
  - Reset mid-cycle drops cyc/stb at once; the transfer is abandoned.
- Address sampling: a transfer is valid when hsel & hready_i & htrans[1] at a rising edge, in IDLE, RESP or ERR2 only.
  - IDLE/BUSY, or hsel=0: zero-wait OKAY, no WB activity.
- Byte-select decode (registered with haddr and hwrite):
  - byte: sel = 1<<haddr[1:0].
  - halfword: haddr[1] ? 1100 : 0011.
  - word: 1111.
- Decode errors, all giving the two-cycle ERROR with no WB cycle:
  - hsize>010.
  - halfword with haddr[0]=1.
  - word with haddr[1:0]!=0.
- FSM states: IDLE, WB_REQ, RESP, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=OKAY. Valid legal transfer → WB_REQ. Illegal → ERR1.
  - WB_REQ:
    - wb_cyc_o=wb_stb_o=1, hreadyout=0.
    - wb_adr_o/wb_we_o/wb_sel_o hold the registered values.
    - wb_dat_o = hwdata (combinational) on writes, 0 on reads.
    - wb_err_i → ERR1. wb_err_i has priority over wb_ack_i when both are high.
    - wb_ack_i → RESP; cyc/stb deassert on that edge; on reads hrdata <= wb_dat_i.
    - Neither → stay.
  - RESP: hreadyout=1, OKAY, hrdata held. Valid transfer → WB_REQ/ERR1 as in IDLE, else IDLE.
  - ERR1: hresp=01, hreadyout=0. Unconditional → ERR2.
  - ERR2: hresp=01, hreadyout=1. Transfer sampled as in RESP.
- Latency: minimum data phase 2 cycles (WB_REQ with ack in same cycle, then RESP).
- Back-to-back throughput: one transfer per 2 cycles with a zero-wait WB slave.
- hrdata changes only on read ack; it is not cleared between transfers.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WB_REQ and increments each WB_REQ cycle.
  - If it reaches TIMEOUT_CYCLES with no ack/err: cyc/stb drop → ERR1. A late ack is ignored.
- Undefined: no counter; WB_REQ waits indefinitely.

Test Plan:
- Word write NONSEQ haddr=0x100, hwdata=0xDEADBEEF, slave acks after 3 cycles → wb_adr_o=0x100, wb_sel_o=1111, wb_we_o=1, wb_dat_o=0xDEADBEEF; hreadyout low 4 cycles, then OKAY.
- Byte read haddr=0x203, slave returns 0x11223344 on zero-wait ack → wb_sel_o=1000; hrdata=0x11223344 with hreadyout=1 in RESP cycle.
- Back-to-back writes 0x0,0x4,0x8 (NONSEQ,SEQ,SEQ), each next address issued during RESP → three WB cycles, no IDLE between, 6 data-phase cycles total.
- wb_err_i=1 together with wb_ack_i on read; separately halfword at haddr=0x1 → ERROR then ERROR+hreadyout=1; no WB cycle for the misaligned case.
- htrans=BUSY, and hsel=1 with hready_i=0 → no WB cycle, hreadyout stays 1, hresp=00.
- hresetn low while wb_cyc_o=1 → cyc/stb/hreadyout reach reset values without a clock edge. With WB_TIMEOUT_EN and no ack, ERROR response after exactly 16 WB_REQ cycles.
